// File: rtl/prog_loader_pkg.sv
// -----------------------------------------------------------------------------
// prog_loader_pkg
// Shared types and constants for the front-panel program loader.
//   state_t     : loader FSM states (IDLE, READY, WRITE, FULL)
//   DATA_W_DEF  : default data word width (matches the 8-bit switch bank)
//   dbnc_cnt_w  : width of a debounce counter able to count DEBOUNCE_CYCLES
// -----------------------------------------------------------------------------
package prog_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READY,
        ST_WRITE,
        ST_FULL
    } state_t;

    localparam int DATA_W_DEF = 8;

    function automatic int dbnc_cnt_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/prog_loader_button.sv
// -----------------------------------------------------------------------------
// button_debouncer
// Two-flop synchronizer, counter debouncer and press-pulse generator for a
// raw active-low push button. Reusable for any front-panel button.
// Ports:
//   clock, reset  : system clock, asynchronous active-high reset
//   i_button_n    : raw button, active-low, asynchronous to clock
//   o_press       : single-cycle pulse when the debounced level falls 1->0
// Parameter DEBOUNCE_CYCLES: consecutive differing samples needed to accept
// a new level.
// -----------------------------------------------------------------------------
module button_debouncer
    import prog_loader_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic i_button_n,
    output logic o_press
);

    localparam int              CW       = dbnc_cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    // The debounced level starts as "pressed" so a button held through reset
    // must be released before it can produce a press.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_button_n;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            // Any sample agreeing with the current level restarts the count,
            // so only an unbroken run of differing samples flips the level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_level_d & ~r_level;

endmodule

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Front-panel program entry: turns debounced button presses and the data
// switches into single-cycle program-memory writes at auto-incrementing
// addresses, tracking program length and a full condition.
// Ports:
//   clock, reset   : system clock, asynchronous active-high reset
//   prog_mode      : 1 = programming, 0 = run
//   prog_button_n  : raw program button, active-low
//   prog_data      : data switches
//   mem_we         : one-cycle write strobe
//   mem_addr       : write address (held between writes)
//   mem_wdata      : write data (held between writes)
//   prog_len       : words written since entering programming mode
//   full           : memory full, further presses ignored
//   checksum       : mod-2^DATA_W sum of written bytes (PROG_CHECKSUM_EN only)
// Optional feature macro: PROG_CHECKSUM_EN
// -----------------------------------------------------------------------------
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W          = 4,
    parameter int DATA_W          = DATA_W_DEF,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              prog_mode,
    input  logic              prog_button_n,
    input  logic [DATA_W-1:0] prog_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W:0]   prog_len,
`ifdef PROG_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              full
);

    localparam int            LW       = ADDR_W + 1;
    localparam int            DEPTH    = 2 ** ADDR_W;
    localparam logic [LW-1:0] LAST_LEN = LW'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_press;
    logic              w_clear;
    logic              w_latch;
    logic              w_commit;
    logic [LW-1:0]     r_len;
    logic              r_full;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button (
        .clock      (clock),
        .reset      (reset),
        .i_button_n (prog_button_n),
        .o_press    (w_press)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Dropping prog_mode wins over everything, so a pending WRITE is
    // abandoned without a strobe and without advancing the length.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_latch     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (prog_mode) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_READY;
                end
            end
            ST_READY: begin
                if (!prog_mode) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_press) begin
                    w_latch     = 1'b1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!prog_mode) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_commit    = 1'b1;
                    w_state_nxt = (r_len == LAST_LEN) ? ST_FULL : ST_READY;
                end
            end
            ST_FULL: begin
                if (!prog_mode) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // prog_len doubles as the write pointer; its low bits are the next address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_len   <= '0;
            r_full  <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            if (w_clear) begin
                r_len  <= '0;
                r_full <= 1'b0;
            end
            if (w_latch) begin
                r_addr  <= r_len[ADDR_W-1:0];
                r_wdata <= prog_data;
            end
            if (w_commit) begin
                r_len <= r_len + 1'b1;
                if (r_len == LAST_LEN) begin
                    r_full <= 1'b1;
                end
            end
        end
    end

`ifdef PROG_CHECKSUM_EN
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_clear) begin
            r_sum <= '0;
        end else if (w_commit) begin
            r_sum <= r_sum + r_wdata;
        end
    end

    assign checksum = r_sum;
`endif

    assign mem_we    = w_commit;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign prog_len  = r_len;
    assign full      = r_full;

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
// Self-checking bench for prog_loader: directed scenarios followed by random
// bouncy presses, glitches, mode changes and resets, compared every cycle
// against a behavioural model of the loader.
// -----------------------------------------------------------------------------
module tb_prog_loader;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DBN    = 4;
    localparam int DEPTH  = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              prog_mode = 1'b0;
    logic              prog_button_n = 1'b1;
    logic [DATA_W-1:0] prog_data = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W:0]   prog_len;
    logic              full;
`ifdef PROG_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    prog_loader #(
        .ADDR_W          (ADDR_W),
        .DATA_W          (DATA_W),
        .DEBOUNCE_CYCLES (DBN)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .prog_mode     (prog_mode),
        .prog_button_n (prog_button_n),
        .prog_data     (prog_data),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .prog_len      (prog_len),
`ifdef PROG_CHECKSUM_EN
        .checksum      (checksum),
`endif
        .full          (full)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Button seen two edges late; level flips after DBN consecutive samples
    // that disagree with it; a fall of the level is a press, acted on one
    // cycle later; the write strobe follows the press by one more cycle.
    logic       m_d1 = 1'b1, m_d2 = 1'b1, m_seen;
    logic       m_lvl = 1'b0;
    int         m_run = 0;
    logic       m_press = 1'b0;
    logic       m_active = 1'b0;
    logic       m_wst = 1'b0;
    int         m_len = 0;
    logic       m_full = 1'b0;
    logic [7:0] m_sum = '0;
    logic [3:0] m_addr = '0;
    logic [7:0] m_wdata = '0;

    int         cyc = 0;
    int         n_we = 0;
    int         last_we_cyc = 0;
    logic [3:0] last_we_addr = '0;
    logic [3:0] we_addrs[$];

    task automatic model_reset();
        m_d1 = 1'b1; m_d2 = 1'b1; m_lvl = 1'b0; m_run = 0; m_press = 1'b0;
        m_active = 1'b0; m_wst = 1'b0; m_len = 0; m_full = 1'b0; m_sum = '0;
        m_addr = '0; m_wdata = '0;
    endtask

    always @(posedge clock) begin
        cyc++;
        if (!reset) begin
            if (!prog_mode) begin
                m_active = 1'b0;
                m_wst    = 1'b0;
            end else if (!m_active) begin
                m_active = 1'b1;
                m_len    = 0;
                m_full   = 1'b0;
                m_sum    = '0;
            end else if (m_wst) begin
                m_len++;
                m_sum = m_sum + m_wdata;
                if (m_len == DEPTH) m_full = 1'b1;
                m_wst = 1'b0;
            end else if (m_press && !m_full) begin
                m_addr  = 4'(m_len);
                m_wdata = prog_data;
                m_wst   = 1'b1;
            end
            m_seen  = m_d2;
            m_d2    = m_d1;
            m_d1    = prog_button_n;
            m_press = 1'b0;
            if (m_seen != m_lvl) begin
                m_run++;
                if (m_run == DBN) begin
                    m_lvl   = m_seen;
                    m_run   = 0;
                    m_press = !m_seen;
                end
            end else begin
                m_run = 0;
            end
        end
    end

    always @(negedge clock) begin
        check("mem_we",    32'(mem_we),    32'(m_wst && prog_mode));
        check("mem_addr",  32'(mem_addr),  32'(m_addr));
        check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
        check("prog_len",  32'(prog_len),  32'(m_len));
        check("full",      32'(full),      32'(m_full));
`ifdef PROG_CHECKSUM_EN
        check("checksum",  32'(checksum),  32'(m_sum));
`endif
        if (mem_we === 1'b1) begin
            n_we++;
            last_we_cyc  = cyc;
            last_we_addr = mem_addr;
            we_addrs.push_back(mem_addr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic hold(input logic b, input int n);
        prog_button_n = b;
        tick(n);
    endtask

    task automatic press(input logic [7:0] d);
        prog_data = d;
        repeat ($urandom_range(0, 2)) begin hold(1'b0, 1); hold(1'b1, 1); end
        hold(1'b0, DBN + 2 + int'($urandom_range(0, 4)));
        repeat ($urandom_range(0, 2)) begin hold(1'b1, 1); hold(1'b0, 1); end
        hold(1'b1, DBN + 3 + int'($urandom_range(0, 4)));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        model_reset();
        tick(n);
        reset = 1'b0;
    endtask

    task automatic reenter();
        prog_mode = 1'b0;
        tick(3);
        prog_mode = 1'b1;
        tick(3);
    endtask

    int         n0, c0;
    logic [7:0] exp_sum;
    logic [7:0] t2_data[4] = '{8'h01, 8'h04, 8'hC0, 8'h00};

    initial begin
        #1;
        prog_mode = 1'b1;
        prog_data = 8'h01;
        do_reset(3);
        check("reset_len",  32'(prog_len), 32'd0);
        check("reset_full", 32'(full),     32'd0);
        check("reset_we",   32'(mem_we),   32'd0);
        tick(3);

        // 1: single press, latency from raw falling edge
        n0 = n_we;
        c0 = cyc;
        hold(1'b0, 10);
        hold(1'b1, 8);
        check("t1_count",   32'(n_we - n0),        32'd1);
        check("t1_latency", 32'(last_we_cyc - c0), 32'd7);
        check("t1_addr",    32'(mem_addr),         32'd0);
        check("t1_wdata",   32'(mem_wdata),        32'h01);
        check("t1_len",     32'(prog_len),         32'd1);

        // 2: four words in order
        reenter();
        we_addrs.delete();
        n0 = n_we;
        foreach (t2_data[i]) press(t2_data[i]);
        check("t2_count", 32'(n_we - n0), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < we_addrs.size()) check("t2_addr_order", 32'(we_addrs[i]), 32'(i));
        end
        check("t2_len", 32'(prog_len), 32'd4);
`ifdef PROG_CHECKSUM_EN
        check("t2_checksum", 32'(checksum), 32'hC5);
`endif

        // 3: short glitches rejected
        n0 = n_we;
        hold(1'b0, 2);
        hold(1'b1, 6);
        repeat (5) begin hold(1'b0, 1); hold(1'b1, 1); end
        hold(1'b0, DBN - 1);
        hold(1'b1, 8);
        check("t3_count", 32'(n_we - n0), 32'd0);
        check("t3_len",   32'(prog_len),  32'd4);

        // 5: run mode ignores presses, re-entry clears
        prog_mode = 1'b0;
        tick(2);
        n0 = n_we;
        press(8'h55);
        check("t5_run_count", 32'(n_we - n0), 32'd0);
        check("t5_run_len",   32'(prog_len),  32'd4);
        prog_mode = 1'b1;
        tick(3);
        check("t5_len_clr",  32'(prog_len), 32'd0);
        check("t5_full_clr", 32'(full),     32'd0);
        press(8'h66);
        check("t5_addr0", 32'(last_we_addr), 32'd0);
        check("t5_len1",  32'(prog_len),     32'd1);

        // 4: fill memory, then an ignored 17th press
        reenter();
        exp_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            prog_data = 8'($urandom);
            exp_sum   = exp_sum + prog_data;
            press(prog_data);
        end
        check("t4_full",  32'(full),     32'd1);
        check("t4_addr",  32'(mem_addr), 32'd15);
        check("t4_len",   32'(prog_len), 32'd16);
`ifdef PROG_CHECKSUM_EN
        check("t4_checksum", 32'(checksum), 32'(exp_sum));
`endif
        n0 = n_we;
        press(8'hAA);
        check("t4_17th_count", 32'(n_we - n0), 32'd0);
        check("t4_17th_len",   32'(prog_len),  32'd16);

        // 6: button held through reset never writes
        prog_button_n = 1'b0;
        tick(3);
        do_reset(4);
        n0 = n_we;
        tick(20);
        check("t6_held_count", 32'(n_we - n0), 32'd0);
        hold(1'b1, 8);
        press(8'h77);
        check("t6_count", 32'(n_we - n0),   32'd1);
        check("t6_addr",  32'(last_we_addr), 32'd0);
        check("t6_len",   32'(prog_len),     32'd1);

        // random phase
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: press(8'($urandom));
                5: begin
                    hold(1'b0, int'($urandom_range(1, DBN - 1)));
                    hold(1'b1, int'($urandom_range(1, 6)));
                end
                6: begin
                    prog_mode = ~prog_mode;
                    tick(int'($urandom_range(1, 4)));
                end
                7: begin
                    prog_data = 8'($urandom);
                    hold(1'b0, int'($urandom_range(3, 9)));
                    prog_mode = ~prog_mode;
                    tick(int'($urandom_range(0, 3)));
                    hold(1'b1, DBN + 4);
                end
                8: begin
                    if ($urandom_range(0, 3) == 0) do_reset(int'($urandom_range(1, 3)));
                    else tick(2);
                end
                default: begin
                    prog_mode = 1'b1;
                    tick(int'($urandom_range(1, 5)));
                end
            endcase
        end
        tick(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
